// File: rtl/config_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : config_pkg
//  Description : Core-wide configuration shared by the IFU predictors.
//                XLEN is the architectural address width; the ICLASS_*
//                constants give bit positions within the 4-bit
//                instruction-class vectors
//                (bit3 call, bit2 return, bit1 jump, bit0 branch).
//  Revision    : 1.0 - initial release
// ============================================================================
package config_pkg;

  localparam int XLEN        = 32;

  localparam int ICLASS_CALL = 3;
  localparam int ICLASS_RET  = 2;
  localparam int ICLASS_JUMP = 1;
  localparam int ICLASS_BR   = 0;

  typedef logic [XLEN-1:0] xlen_t;

endpackage : config_pkg
`default_nettype wire

// File: rtl/ras_stack.sv
`default_nettype none
// ============================================================================
//  Module      : ras_stack
//  Description : DEPTH x XLEN register array backing the return address
//                stack. One synchronous write port, one asynchronous read
//                port, and a synchronous clear of every entry on reset.
//  Ports       : clk, reset       - clock, synchronous active-high reset
//                we_i, waddr_i    - write enable and write index
//                wdata_i          - write data
//                raddr_i          - read index
//                rdata_o          - stack[raddr_i], combinational
//  Revision    : 1.0 - initial release
// ============================================================================
module ras_stack
  import config_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  logic [XLEN-1:0]  wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output logic [XLEN-1:0]  rdata_o
);

  logic [XLEN-1:0] mem_q [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    always_ff @(posedge clk) begin
      if (reset) begin
        mem_q[i] <= '0;
      end else if (we_i && (waddr_i == PTR_W'(i))) begin
        mem_q[i] <= wdata_i;
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : ras_stack
`default_nettype wire

// File: rtl/ras_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : ras_predictor
//  Description : Speculative return address stack. Pops in Fetch on the BTB
//                return guess, pushes call link addresses in Execute, and
//                repairs the pointer when speculative pops are flushed or
//                the BTB return guess turns out false.
//                Optional feature macro: RAS_REPAIR_EN (pointer repair,
//                popped-flag pipeline and RASPCWrongE). Without it, every
//                fetch pop is permanent and RASPCWrongE is 0.
//  Ports       : clk, reset                 - clock, sync active-high reset
//                StallF/D/E/M, FlushD/E/M   - pipeline control
//                BTBIClassF                 - BTB class guess in Fetch
//                IClassD, IClassE           - decoded class in D and E
//                PCLinkE                    - link address of call in E
//                IEUAdrE                    - resolved target in E
//                RASPCF                     - predicted return address
//                RASPCWrongE                - E return mispredicted by RAS
//  Revision    : 1.0 - initial release
// ============================================================================
module ras_predictor
  import config_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            StallE,
  input  logic            StallM,
  input  logic            FlushD,
  input  logic            FlushE,
  input  logic            FlushM,
  input  logic [3:0]      BTBIClassF,
  input  logic [3:0]      IClassD,
  input  logic [3:0]      IClassE,
  input  logic [XLEN-1:0] PCLinkE,
  input  logic [XLEN-1:0] IEUAdrE,
  output logic [XLEN-1:0] RASPCF,
  output logic            RASPCWrongE
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  Ptr_q, Ptr_d;
  logic [PTR_W-1:0]  PtrAdj, WrAdr;
  logic signed [2:0] AdjDelta, Delta;
  logic              PopF, PushE, LatePopE, RepD, RepE, FalseE;
  logic [XLEN-1:0]   StackTop;

  assign PopF  = BTBIClassF[ICLASS_RET]  & ~StallF & ~FlushD;
  assign PushE = IClassE[ICLASS_CALL]    & ~StallE & ~FlushM;

`ifdef RAS_REPAIR_EN
  logic            PoppedD_q, PoppedE_q;
  logic [XLEN-1:0] RASPCD_q, RASPCE_q;

  // Enable-then-clear flops: a flush only takes effect when the stage
  // is not stalled, matching how the rest of the pipeline advances.
  always_ff @(posedge clk) begin
    if (reset) begin
      PoppedD_q <= 1'b0;
      RASPCD_q  <= '0;
    end else if (~StallD) begin
      if (FlushD) begin
        PoppedD_q <= 1'b0;
        RASPCD_q  <= '0;
      end else begin
        PoppedD_q <= PopF;
        RASPCD_q  <= RASPCF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      PoppedE_q <= 1'b0;
      RASPCE_q  <= '0;
    end else if (~StallE) begin
      if (FlushE) begin
        PoppedE_q <= 1'b0;
        RASPCE_q  <= '0;
      end else begin
        PoppedE_q <= PoppedD_q;
        RASPCE_q  <= RASPCD_q;
      end
    end
  end

  // A return in E that never popped in F was missed by the BTB.
  assign LatePopE = IClassE[ICLASS_RET] & ~PoppedE_q & ~StallE & ~FlushM;
  assign RepD     = FlushE & PoppedD_q;
  assign RepE     = FlushM & PoppedE_q;
  assign FalseE   = PoppedE_q & ~IClassE[ICLASS_RET] & ~StallE & ~FlushM;

  assign RASPCWrongE = ~reset & IClassE[ICLASS_RET] & PoppedE_q &
                       (RASPCE_q != IEUAdrE);

  logic unused_sigs;
  assign unused_sigs = ^{StallM, IClassD, BTBIClassF[3], BTBIClassF[1:0],
                         IClassE[1:0]};
`else
  // Without the flag pipeline every return is assumed to have popped in
  // fetch, so there is no late pop and nothing to repair.
  assign LatePopE    = 1'b0;
  assign RepD        = 1'b0;
  assign RepE        = 1'b0;
  assign FalseE      = 1'b0;
  assign RASPCWrongE = 1'b0;

  logic unused_sigs;
  assign unused_sigs = ^{StallD, StallM, FlushE, IClassD, IEUAdrE,
                         BTBIClassF[3], BTBIClassF[1:0], IClassE[2:0]};
`endif

  // Signed deltas: AdjDelta moves Ptr to the position the push builds on;
  // Delta is the full per-cycle change (-2..+3).
  always_comb begin
    AdjDelta = {2'b00, RepD} + {2'b00, RepE} + {2'b00, FalseE}
             - {2'b00, LatePopE};
    Delta    = AdjDelta - {2'b00, PopF} + {2'b00, PushE};
  end

  // Sized casts of signed deltas sign-extend (or truncate for tiny DEPTH);
  // the add then wraps modulo DEPTH.
  assign PtrAdj = Ptr_q + PTR_W'(AdjDelta);
  assign Ptr_d  = Ptr_q + PTR_W'(Delta);
  assign WrAdr  = PtrAdj + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      Ptr_q <= '0;
    end else begin
      Ptr_q <= Ptr_d;
    end
  end

  ras_stack #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_stack (
    .clk     (clk),
    .reset   (reset),
    .we_i    (PushE),
    .waddr_i (WrAdr),
    .wdata_i (PCLinkE),
    .raddr_i (Ptr_q),
    .rdata_o (StackTop)
  );

  // A call in E is older than the return being fetched, so its link
  // address is forwarded straight to fetch.
  always_comb begin
    RASPCF = StackTop;
    if (PushE) RASPCF = PCLinkE;
    if (reset) RASPCF = '0;
  end

endmodule : ras_predictor
`default_nettype wire

// File: tb/tb_ras_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ras_predictor
//  Description : Directed self-checking bench for ras_predictor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ras_predictor;
  import config_pkg::*;

  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            StallF, StallD, StallE, StallM;
  logic            FlushD, FlushE, FlushM;
  logic [3:0]      BTBIClassF, IClassD, IClassE;
  logic [XLEN-1:0] PCLinkE, IEUAdrE;
  logic [XLEN-1:0] RASPCF;
  logic            RASPCWrongE;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ras_predictor #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .StallF      (StallF),
    .StallD      (StallD),
    .StallE      (StallE),
    .StallM      (StallM),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .FlushM      (FlushM),
    .BTBIClassF  (BTBIClassF),
    .IClassD     (IClassD),
    .IClassE     (IClassE),
    .PCLinkE     (PCLinkE),
    .IEUAdrE     (IEUAdrE),
    .RASPCF      (RASPCF),
    .RASPCWrongE (RASPCWrongE)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] obs,
                     input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    StallF = 0; StallD = 0; StallE = 0; StallM = 0;
    FlushD = 0; FlushE = 0; FlushM = 0;
    BTBIClassF = 4'b0000; IClassD = 4'b0000; IClassE = 4'b0000;
    PCLinkE = '0; IEUAdrE = '0;
  endtask

  task automatic do_reset(input string tag);
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk({tag, "_rst_pcf"}, RASPCF, '0);
    chk({tag, "_rst_wrong"}, XLEN'(RASPCWrongE), '0);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();

    // Push 0x100, 0x200 then two fetch pops.
    do_reset("pp");
    IClassE = 4'b1000; PCLinkE = 32'h100; #1;
    chk("pp_push1_byp", RASPCF, 32'h100);
    tick();
    PCLinkE = 32'h200; #1;
    chk("pp_push2_byp", RASPCF, 32'h200);
    tick();
    IClassE = 4'b0000; PCLinkE = '0; BTBIClassF = 4'b0100; #1;
    chk("pp_pop1", RASPCF, 32'h200);
    tick();
    #1;
    chk("pp_pop2", RASPCF, 32'h100);
    tick();
    BTBIClassF = 4'b0000; #1;
    chk("pp_empty", RASPCF, 32'h0);

    // Bypass: push in E in the same cycle as a fetch pop.
    do_reset("byp");
    IClassE = 4'b1000; PCLinkE = 32'h300; BTBIClassF = 4'b0100; #1;
    chk("byp_same_cycle", RASPCF, 32'h300);
    tick();
    idle(); #1;
    chk("byp_after", RASPCF, 32'h0);

    // Stalled or flushed fetch must not pop.
    do_reset("sf");
    IClassE = 4'b1000; PCLinkE = 32'h500; tick();
    idle(); BTBIClassF = 4'b0100; StallF = 1; FlushD = 1; tick();
    idle(); BTBIClassF = 4'b0100; StallF = 1; tick();
    idle(); #1;
    chk("sf_nopop", RASPCF, 32'h500);

`ifdef RAS_REPAIR_EN
    // Flush of a speculatively popped instruction in D.
    do_reset("fl");
    IClassE = 4'b1000; PCLinkE = 32'h100; tick();
    idle(); BTBIClassF = 4'b0100; #1;
    chk("fl_pop", RASPCF, 32'h100);
    tick();
    idle(); FlushE = 1; #1;
    chk("fl_during", RASPCF, 32'h0);
    tick();
    idle(); BTBIClassF = 4'b0100; #1;
    chk("fl_repaired", RASPCF, 32'h100);

    // False return: popped instruction turns out to be a branch.
    do_reset("fr");
    IClassE = 4'b1000; PCLinkE = 32'h100; tick();
    idle(); BTBIClassF = 4'b0100; tick();
    idle(); #1;
    chk("fr_popped", RASPCF, 32'h0);
    tick();
    IClassE = 4'b0001; #1;
    chk("fr_wrong", XLEN'(RASPCWrongE), '0);
    tick();
    idle(); #1;
    chk("fr_repaired", RASPCF, 32'h100);

    // Mispredicted return target.
    do_reset("mp");
    IClassE = 4'b1000; PCLinkE = 32'h400; tick();
    idle(); BTBIClassF = 4'b0100; tick();
    idle(); tick();
    IClassE = 4'b0100; IEUAdrE = 32'h404; #1;
    chk("mp_wrong", XLEN'(RASPCWrongE), 32'h1);
    tick();
    idle(); IEUAdrE = 32'h404; #1;
    chk("mp_wrong_clear", XLEN'(RASPCWrongE), 32'h0);
`else
    // Pops are permanent and no mispredict is ever flagged.
    do_reset("pm");
    IClassE = 4'b1000; PCLinkE = 32'h100; tick();
    PCLinkE = 32'h200; tick();
    idle(); BTBIClassF = 4'b0100; #1;
    chk("pm_pop", RASPCF, 32'h200);
    tick();
    idle(); IClassE = 4'b0001; tick(); tick(); tick();
    #1;
    chk("pm_permanent", RASPCF, 32'h100);
    IClassE = 4'b0100; IEUAdrE = 32'hDEAD; #1;
    chk("pm_wrong", XLEN'(RASPCWrongE), '0);
    tick();
    idle(); #1;
    chk("pm_noret_pop", RASPCF, 32'h100);
`endif

    // Wrap: DEPTH+1 pushes; the last lands in entry 1.
    do_reset("wr");
    for (int i = 1; i <= DEPTH + 1; i++) begin
      IClassE = 4'b1000; PCLinkE = 32'h1000 + i; tick();
    end
    idle(); #1;
    chk("wr_top", RASPCF, 32'h1000 + DEPTH + 1);
    BTBIClassF = 4'b0100; tick();
    idle(); #1;
    chk("wr_below", RASPCF, 32'h1000 + DEPTH);
    IClassE = 4'b1000; PCLinkE = 32'h7777; reset = 1'b1; #1;
    chk("wr_in_reset", RASPCF, 32'h0);
    tick();
    reset = 1'b0; idle(); #1;
    chk("wr_after_reset", RASPCF, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ras_predictor
`default_nettype wire
